// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: global scatter/chase/frightened sequencer shared by the four ghosts.
// Optional `FRIGHT_SCORE_COMBO_EN: ghost-eaten score doubles 200..1600; otherwise a flat 200.
module ghost_mode_scheduler #(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int SCATTER_LONG_S  = 7,
  parameter int SCATTER_SHORT_S = 5,
  parameter int CHASE_S         = 20,
  parameter int FRIGHT_S        = 10,
  parameter int FLASH_S         = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        level_start,
  input  logic        soft_reset,
  input  logic        power_pellet,
  input  logic [3:0]  ghost_eaten_i,
  input  logic [3:0]  ghost_home_i,
  output logic [1:0]  mode_o,
  output logic [1:0]  round_o,
  output logic [3:0]  fright_active_o,
  output logic [3:0]  ghost_dead_o,
  output logic        fright_flash_o,
  output logic        score_valid_o,
  output logic [10:0] score_o
);
  localparam int FW = $clog2(FRAMES_PER_SEC);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0] SCAT_LONG  = 7'(SCATTER_LONG_S);
  localparam logic [6:0] SCAT_SHORT = 7'(SCATTER_SHORT_S);
  localparam logic [6:0] CHASE_LEN  = 7'(CHASE_S);
  localparam logic [6:0] FRIGHT_LEN = 7'(FRIGHT_S);
  localparam logic [6:0] FLASH_FROM = 7'(FRIGHT_S - FLASH_S);
  localparam logic [10:0] SCORE_BASE = 11'd200;

  typedef enum logic [1:0] {ST_WAIT, ST_SCATTER, ST_CHASE, ST_FRIGHT} state_t;

  state_t        state, state_nxt;
  logic          resume_chase, resume_nxt;
  logic [FW-1:0] frame_cnt, frame_nxt, fframe, fframe_nxt;
  logic [6:0]    sec_cnt, sec_nxt, fsec, fsec_nxt, sec_up;
  logic [3:0]    pending, pend_nxt, eat_ok, grant, fa_nxt, dead_nxt;
  logic [1:0]    mode_nxt, round_nxt;
  logic          flash_nxt, sv_nxt;
  logic [10:0]   score_nxt;
`ifdef FRIGHT_SCORE_COMBO_EN
  localparam logic [10:0] SCORE_MAX = 11'd1600;
  logic [10:0]   combo, combo_nxt;
`endif

  function automatic logic [6:0] sec_inc(input logic [6:0] s);
    return (s == 7'h7F) ? s : s + 7'd1;
  endfunction

  function automatic logic flash_phase(input logic [FW-1:0] f);
    int fi;
    fi = int'(f);
    return (fi >= 10 && fi <= 19) || (fi >= 30 && fi <= 39) || (fi >= 50 && fi <= 59);
  endfunction

  always_comb begin
    state_nxt  = state;
    resume_nxt = resume_chase;
    round_nxt  = round_o;
    frame_nxt  = frame_cnt;
    sec_nxt    = sec_cnt;
    fframe_nxt = fframe;
    fsec_nxt   = fsec;
    sec_up     = 7'd0;
    eat_ok     = ghost_eaten_i & fright_active_o;
    dead_nxt   = (ghost_dead_o & ~ghost_home_i) | eat_ok;
    fa_nxt     = fright_active_o & ~eat_ok;
    grant      = pending & (~pending + 4'd1);
    pend_nxt   = (pending & ~grant) | eat_ok;
    sv_nxt     = (pending != 4'd0);
    score_nxt  = 11'd0;
`ifdef FRIGHT_SCORE_COMBO_EN
    combo_nxt  = combo;
    if (sv_nxt) begin
      score_nxt = combo;
      combo_nxt = (combo >= SCORE_MAX) ? SCORE_MAX : combo << 1;
    end
`else
    if (sv_nxt) score_nxt = SCORE_BASE;
`endif

    unique case (state)
      ST_WAIT: begin
        if (level_start) begin
          state_nxt = ST_SCATTER;
          frame_nxt = '0;
          sec_nxt   = 7'd0;
          round_nxt = 2'd0;
        end
      end
      ST_SCATTER, ST_CHASE: begin
        if (power_pellet) begin
          state_nxt  = ST_FRIGHT;
          resume_nxt = (state == ST_CHASE);
          fa_nxt     = ~ghost_dead_o & ~eat_ok;
          fframe_nxt = '0;
          fsec_nxt   = 7'd0;
`ifdef FRIGHT_SCORE_COMBO_EN
          combo_nxt  = SCORE_BASE;
`endif
        end else if (frame_tick) begin
          if (frame_cnt == FRAME_LAST) begin
            sec_up    = sec_inc(sec_cnt);
            frame_nxt = '0;
            sec_nxt   = sec_up;
            if (state == ST_SCATTER &&
                sec_up >= (round_o[1] ? SCAT_SHORT : SCAT_LONG)) begin
              state_nxt = ST_CHASE;
              sec_nxt   = 7'd0;
            end else if (state == ST_CHASE && round_o != 2'd3 && sec_up >= CHASE_LEN) begin
              state_nxt = ST_SCATTER;
              round_nxt = round_o + 2'd1;
              sec_nxt   = 7'd0;
            end
          end else begin
            frame_nxt = frame_cnt + 1'b1;
          end
        end
      end
      ST_FRIGHT: begin
        // Base-mode counters stay frozen for the whole fright period.
        if (power_pellet) begin
          fa_nxt     = ~ghost_dead_o & ~eat_ok;
          fframe_nxt = '0;
          fsec_nxt   = 7'd0;
`ifdef FRIGHT_SCORE_COMBO_EN
          combo_nxt  = SCORE_BASE;
`endif
        end else if (frame_tick) begin
          if (fframe == FRAME_LAST) begin
            fframe_nxt = '0;
            fsec_nxt   = sec_inc(fsec);
            if (fsec_nxt >= FRIGHT_LEN) begin
              state_nxt = resume_chase ? ST_CHASE : ST_SCATTER;
              fa_nxt    = 4'd0;
              fsec_nxt  = 7'd0;
            end
          end else begin
            fframe_nxt = fframe + 1'b1;
          end
        end
      end
      default: state_nxt = ST_WAIT;
    endcase

    if (soft_reset) begin
      state_nxt  = ST_WAIT;
      resume_nxt = 1'b0;
      round_nxt  = 2'd0;
      frame_nxt  = '0;
      sec_nxt    = 7'd0;
      fframe_nxt = '0;
      fsec_nxt   = 7'd0;
      fa_nxt     = 4'd0;
      dead_nxt   = 4'd0;
      pend_nxt   = 4'd0;
      sv_nxt     = 1'b0;
      score_nxt  = 11'd0;
`ifdef FRIGHT_SCORE_COMBO_EN
      combo_nxt  = SCORE_BASE;
`endif
    end

    unique case (state_nxt)
      ST_SCATTER: mode_nxt = 2'd1;
      ST_CHASE:   mode_nxt = 2'd2;
      ST_FRIGHT:  mode_nxt = resume_nxt ? 2'd2 : 2'd1;
      default:    mode_nxt = 2'd0;
    endcase
    flash_nxt = (state_nxt == ST_FRIGHT) && (fsec_nxt >= FLASH_FROM) && flash_phase(fframe_nxt);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state           <= ST_WAIT;
      resume_chase    <= 1'b0;
      round_o         <= 2'd0;
      mode_o          <= 2'd0;
      frame_cnt       <= '0;
      sec_cnt         <= 7'd0;
      fframe          <= '0;
      fsec            <= 7'd0;
      fright_active_o <= 4'd0;
      ghost_dead_o    <= 4'd0;
      pending         <= 4'd0;
      fright_flash_o  <= 1'b0;
      score_valid_o   <= 1'b0;
      score_o         <= 11'd0;
`ifdef FRIGHT_SCORE_COMBO_EN
      combo           <= SCORE_BASE;
`endif
    end else begin
      state           <= state_nxt;
      resume_chase    <= resume_nxt;
      round_o         <= round_nxt;
      mode_o          <= mode_nxt;
      frame_cnt       <= frame_nxt;
      sec_cnt         <= sec_nxt;
      fframe          <= fframe_nxt;
      fsec            <= fsec_nxt;
      fright_active_o <= fa_nxt;
      ghost_dead_o    <= dead_nxt;
      pending         <= pend_nxt;
      fright_flash_o  <= flash_nxt;
      score_valid_o   <= sv_nxt;
      score_o         <= score_nxt;
`ifdef FRIGHT_SCORE_COMBO_EN
      combo           <= combo_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: directed game scenarios plus random play, each cycle
// compared against a tick-counting reference model of the mode/fright/score rules.
module tb_ghost_mode_scheduler;
  localparam int FPS = 60, SL = 7, SS = 5, CH = 20, FR = 10, FL = 5;
`ifdef FRIGHT_SCORE_COMBO_EN
  localparam int SECOND_SCORE = 400;
`else
  localparam int SECOND_SCORE = 200;
`endif

  logic        Clk = 1'b0;
  logic        Reset, frame_tick, level_start, soft_reset, power_pellet;
  logic [3:0]  ghost_eaten_i, ghost_home_i;
  logic [1:0]  mode_o, round_o;
  logic [3:0]  fright_active_o, ghost_dead_o;
  logic        fright_flash_o, score_valid_o;
  logic [10:0] score_o;

  ghost_mode_scheduler #(
    .FRAMES_PER_SEC(FPS), .SCATTER_LONG_S(SL), .SCATTER_SHORT_S(SS),
    .CHASE_S(CH), .FRIGHT_S(FR), .FLASH_S(FL)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .level_start(level_start),
    .soft_reset(soft_reset), .power_pellet(power_pellet),
    .ghost_eaten_i(ghost_eaten_i), .ghost_home_i(ghost_home_i),
    .mode_o(mode_o), .round_o(round_o), .fright_active_o(fright_active_o),
    .ghost_dead_o(ghost_dead_o), .fright_flash_o(fright_flash_o),
    .score_valid_o(score_valid_o), .score_o(score_o)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: elapsed ticks per phase, membership masks, pending set.
  int         m_mode, m_round, m_base_el, m_fr_el, m_combo, m_score;
  bit         m_fr, m_sv, m_flash;
  logic [3:0] m_fa, m_dead, m_pend;

  task automatic model_reset();
    m_mode = 0; m_round = 0; m_base_el = 0; m_fr = 0; m_fr_el = 0;
    m_fa = 4'd0; m_dead = 4'd0; m_pend = 4'd0; m_combo = 200;
    m_sv = 0; m_score = 0; m_flash = 0;
  endtask

  task automatic model_step();
    logic [3:0] eat, old_dead;
    int len;
    if (soft_reset) begin
      model_reset();
      return;
    end
    m_sv = 0;
    m_score = 0;
    for (int g = 0; g < 4; g++) begin
      if (m_pend[g]) begin
        m_pend[g] = 1'b0;
        m_sv = 1;
        m_score = m_combo;
`ifdef FRIGHT_SCORE_COMBO_EN
        m_combo = (m_combo * 2 > 1600) ? 1600 : m_combo * 2;
`endif
        break;
      end
    end
    old_dead = m_dead;
    eat = ghost_eaten_i & m_fa;
    m_dead = (m_dead & ~ghost_home_i) | eat;
    m_fa = m_fa & ~eat;
    m_pend = m_pend | eat;
    if (m_mode == 0) begin
      if (level_start) begin
        m_mode = 1; m_round = 0; m_base_el = 0;
      end
    end else if (power_pellet) begin
      m_fr = 1; m_fr_el = 0; m_fa = ~old_dead & ~eat; m_combo = 200;
    end else if (m_fr) begin
      if (frame_tick) begin
        m_fr_el++;
        if (m_fr_el == FR * FPS) begin
          m_fr = 0; m_fr_el = 0; m_fa = 4'd0;
        end
      end
    end else if (frame_tick) begin
      m_base_el++;
      if (m_mode == 1) len = (m_round < 2 ? SL : SS) * FPS;
      else             len = (m_round < 3) ? CH * FPS : 0;
      if (len != 0 && m_base_el == len) begin
        m_base_el = 0;
        if (m_mode == 1) m_mode = 2;
        else begin
          m_mode = 1;
          m_round++;
        end
      end
    end
    m_flash = m_fr && (m_fr_el >= (FR - FL) * FPS) && ((m_fr_el % FPS) % 20 >= 10);
  endtask

  task automatic compare_all();
    check("mode", 32'(mode_o), 32'(m_mode));
    check("round", 32'(round_o), 32'(m_round));
    check("fright_active", 32'(fright_active_o), 32'(m_fa));
    check("ghost_dead", 32'(ghost_dead_o), 32'(m_dead));
    check("flash", 32'(fright_flash_o), 32'(m_flash));
    check("score_valid", 32'(score_valid_o), 32'(m_sv));
    if (m_sv) check("score", 32'(score_o), 32'(m_score));
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; level_start = 1'b0; soft_reset = 1'b0;
    power_pellet = 1'b0; ghost_eaten_i = 4'd0; ghost_home_i = 4'd0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_mode", 32'(mode_o), 32'd0);
    check("rst_round", 32'(round_o), 32'd0);
    check("rst_fa", 32'(fright_active_o), 32'd0);
    check("rst_dead", 32'(ghost_dead_o), 32'd0);
    check("rst_flash", 32'(fright_flash_o), 32'd0);
    check("rst_sv", 32'(score_valid_o), 32'd0);
    check("rst_score", 32'(score_o), 32'd0);
    Reset = 1'b0;
    frame_tick = 1'b1;
    run(5);

    // Full scatter/chase schedule, then round 3 chase persists.
    level_start = 1'b1; cycle(); level_start = 1'b0;
    check("start_scatter", 32'(mode_o), 32'd1);
    run(420);
    check("first_chase", 32'(mode_o), 32'd2);
    run(1200);
    check("round1_scatter", 32'(mode_o), 32'd1);
    check("round1", 32'(round_o), 32'd1);
    run(420 + 1200 + 300 + 1200 + 300 + 10000);
    check("round3_chase", 32'(mode_o), 32'd2);
    check("round3", 32'(round_o), 32'd3);

    // soft_reset wins over a simultaneous power pellet; pellet in WAIT is ignored.
    soft_reset = 1'b1; power_pellet = 1'b1; cycle(); soft_reset = 1'b0; power_pellet = 1'b0;
    check("softrst_mode", 32'(mode_o), 32'd0);
    check("softrst_fa", 32'(fright_active_o), 32'd0);
    power_pellet = 1'b1; cycle(); power_pellet = 1'b0;
    run(3);
    check("wait_pellet_fa", 32'(fright_active_o), 32'd0);

    // Fright during scatter, two ghosts eaten together, re-entry with dead ghosts.
    level_start = 1'b1; cycle(); level_start = 1'b0;
    run(99);
    power_pellet = 1'b1; cycle(); power_pellet = 1'b0;
    check("fright_all", 32'(fright_active_o), 32'hF);
    check("fright_base_mode", 32'(mode_o), 32'd1);
    run(10);
    ghost_eaten_i = 4'b1010; cycle(); ghost_eaten_i = 4'd0;
    check("eaten_dead", 32'(ghost_dead_o), 32'b1010);
    cycle();
    check("score_first", 32'(score_o), 32'd200);
    cycle();
    check("score_second", 32'(score_o), 32'(SECOND_SCORE));
    run(50);
    power_pellet = 1'b1; cycle(); power_pellet = 1'b0;
    check("reentry_fa", 32'(fright_active_o), 32'b0101);
    ghost_home_i = 4'b0010; cycle(); ghost_home_i = 4'd0;
    check("home_dead", 32'(ghost_dead_o), 32'b1000);
    check("home_fa", 32'(fright_active_o), 32'b0101);
    run(700);

    // Random play.
    for (int i = 0; i < 20000; i++) begin
      frame_tick    = ($urandom_range(0, 7) != 0);
      level_start   = ($urandom_range(0, 199) == 0);
      power_pellet  = ($urandom_range(0, 1499) == 0);
      ghost_eaten_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      ghost_home_i  = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      soft_reset    = ($urandom_range(0, 4999) == 0);
      cycle();
    end
    level_start = 1'b0; power_pellet = 1'b0; soft_reset = 1'b0;
    ghost_eaten_i = 4'd0; ghost_home_i = 4'd0;
    run(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
